// File: rtl/axis_to_axi_pkg.sv
// Shared types for the AXI-Stream-to-AXI write scheduler.
//   axi_resp_e    : AXI BRESP encodings
//   sched_state_e : scheduler FSM states
//   burst_cmd_t   : one burst command (start address, AWLEN, last-of-frame)
//   AXI_4KB       : AXI burst boundary in bytes
package axis_to_axi_pkg;

   typedef enum logic [1:0] {
      AXI_OKAY   = 2'b00,
      AXI_EXOKAY = 2'b01,
      AXI_SLVERR = 2'b10,
      AXI_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_WAIT_RESP,
      S_DONE
   } sched_state_e;

   localparam int CMD_ADDR_W = 32;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic                  last;
   } burst_cmd_t;

   localparam int AXI_4KB = 4096;

endpackage

// File: rtl/axis_to_axi_burst_calc.sv
// Combinational burst sizer: returns the largest burst (in beats) that
// covers no more than the remaining beats, the maximum burst length, the
// distance to the next 4 KB boundary and the distance to the ring end.
//   beats_rem  : beats still to issue for the frame
//   addr_lo    : low 12 bits of the burst start address
//   ring_bytes : ring size in bytes
//   wptr       : current ring offset in bytes
//   burst      : resulting burst length in beats (1..MAX_BURST when beats_rem > 0)
module axis_to_axi_burst_calc
   import axis_to_axi_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 24,
   parameter int BPB       = 4,
   parameter int MAX_BURST = 16
) (
   input  logic [LEN_W-1:0]  beats_rem,
   input  logic [11:0]       addr_lo,
   input  logic [ADDR_W-1:0] ring_bytes,
   input  logic [ADDR_W-1:0] wptr,
   output logic [8:0]        burst
);

   localparam int BPB_LG = $clog2(BPB);
   localparam int CW     = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

   logic [CW-1:0] lim_4k;
   logic [CW-1:0] lim_ring;
   logic [CW-1:0] m;

   always_comb begin
      lim_4k   = CW'((13'(AXI_4KB) - {1'b0, addr_lo}) >> BPB_LG);
      lim_ring = CW'((ring_bytes - wptr) >> BPB_LG);
      m        = CW'(beats_rem);
      if (m > CW'(MAX_BURST)) m = CW'(MAX_BURST);
      if (lim_4k < m)         m = lim_4k;
      if (lim_ring < m)       m = lim_ring;
      burst = 9'(m);
   end

endmodule

// File: rtl/axis_to_axi_wr_sched.sv
// Write-burst scheduler: takes one frame request at a time, places it at the
// ring write pointer and splits it into AXI bursts for the writer, then waits
// for every B response and reports the frame with an accumulated error flag.
//   axi_aclk / axi_areset      : clock, synchronous active-high reset
//   cfg_*                      : enable, ring base and ring size (sampled in IDLE)
//   req_valid/ready/bytes      : frame request
//   cmd_valid/ready/addr/len/last : burst command to the writer
//   bresp_valid / bresp        : one B response per burst, in order
//   done_*                     : one-cycle frame completion report
//   busy                       : FSM active or responses still pending
//
// state     | meaning
// IDLE      | waiting for a frame request
// CALC      | sizing the next burst
// ISSUE     | presenting the burst command to the writer
// WAIT_RESP | all bursts issued, waiting for outstanding B responses
// DONE      | one-cycle completion pulse
module axis_to_axi_wr_sched
   import axis_to_axi_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH    = 32,
   parameter int AXI_DATA_WIDTH    = 32,
   parameter int AXI_MAX_BURST_LEN = 16,
   parameter int MAX_OUTSTANDING   = 8,
   parameter int LEN_WIDTH         = 24
) (
   input  logic                      axi_aclk,
   input  logic                      axi_areset,
   input  logic                      cfg_enable,
   input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [AXI_ADDR_WIDTH-1:0] cfg_ring_bytes,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [LEN_WIDTH-1:0]      req_bytes,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
   output logic [7:0]                cmd_len,
   output logic                      cmd_last,
   input  logic                      bresp_valid,
   input  logic [1:0]                bresp,
   output logic                      done_valid,
   output logic [AXI_ADDR_WIDTH-1:0] done_addr,
   output logic [LEN_WIDTH-1:0]      done_bytes,
   output logic                      done_err,
   output logic                      busy
);

   localparam int BPB    = AXI_DATA_WIDTH / 8;
   localparam int BPB_LG = $clog2(BPB);
   localparam int OW     = $clog2(MAX_OUTSTANDING) + 1;

   sched_state_e              state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
   logic [AXI_ADDR_WIDTH-1:0] ring_q, ring_d;
   logic [AXI_ADDR_WIDTH-1:0] frame_addr_q, frame_addr_d;
   logic [LEN_WIDTH-1:0]      frame_bytes_q, frame_bytes_d;
   logic [LEN_WIDTH-1:0]      beats_rem_q, beats_rem_d;
   logic [8:0]                burst_q, burst_d;
   burst_cmd_t                cmd_q, cmd_d;
   logic                      err_acc_q, err_acc_d;
   logic [OW-1:0]             outst_q, outst_d;

   logic [AXI_ADDR_WIDTH-1:0] calc_addr;
   logic [AXI_ADDR_WIDTH-1:0] wptr_adv;
   logic [LEN_WIDTH-1:0]      req_beats;
   logic [8:0]                calc_burst;
   logic                      cmd_hs;
   logic                      resp_take;

   assign calc_addr = base_q + wptr_q;
   assign wptr_adv  = wptr_q + (AXI_ADDR_WIDTH'(burst_q) << BPB_LG);
   assign req_beats = LEN_WIDTH'(({1'b0, req_bytes} + (LEN_WIDTH+1)'(BPB - 1)) >> BPB_LG);

   axis_to_axi_burst_calc #(
      .ADDR_W    (AXI_ADDR_WIDTH),
      .LEN_W     (LEN_WIDTH),
      .BPB       (BPB),
      .MAX_BURST (AXI_MAX_BURST_LEN)
   ) u_burst_calc (
      .beats_rem  (beats_rem_q),
      .addr_lo    (calc_addr[11:0]),
      .ring_bytes (ring_q),
      .wptr       (wptr_q),
      .burst      (calc_burst)
   );

   always_comb begin
      state_d       = state_q;
      wptr_d        = wptr_q;
      base_d        = base_q;
      ring_d        = ring_q;
      frame_addr_d  = frame_addr_q;
      frame_bytes_d = frame_bytes_q;
      beats_rem_d   = beats_rem_q;
      burst_d       = burst_q;
      cmd_d         = cmd_q;
      err_acc_d     = err_acc_q;
      outst_d       = outst_q;
      req_ready     = 1'b0;
      cmd_valid     = 1'b0;
      done_valid    = 1'b0;

      // A response with nothing outstanding belongs to no burst we know of.
      resp_take = bresp_valid && (outst_q != '0);
      if (resp_take && (axi_resp_e'(bresp) != AXI_OKAY)) err_acc_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            req_ready = cfg_enable;
            if (req_valid && cfg_enable) begin
               base_d        = cfg_base_addr;
               ring_d        = cfg_ring_bytes;
               frame_addr_d  = cfg_base_addr + wptr_q;
               beats_rem_d   = req_beats;
               frame_bytes_d = req_beats << BPB_LG;
               err_acc_d     = 1'b0;
               state_d       = (req_beats == '0) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            cmd_d.addr = CMD_ADDR_W'(calc_addr);
            cmd_d.len  = 8'(calc_burst - 9'd1);
            cmd_d.last = (LEN_WIDTH'(calc_burst) == beats_rem_q);
            burst_d    = calc_burst;
            state_d    = S_ISSUE;
         end
         S_ISSUE: begin
            // Outstanding only falls while waiting here, so once raised
            // cmd_valid holds until the handshake.
            cmd_valid = (outst_q < OW'(MAX_OUTSTANDING));
            if (cmd_valid && cmd_ready) begin
               wptr_d      = (wptr_adv == ring_q) ? '0 : wptr_adv;
               beats_rem_d = beats_rem_q - LEN_WIDTH'(burst_q);
               state_d     = cmd_q.last ? S_WAIT_RESP : S_CALC;
            end
         end
         S_WAIT_RESP: begin
            if (outst_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            done_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      cmd_hs = cmd_valid && cmd_ready;
      if (cmd_hs && !resp_take)      outst_d = outst_q + OW'(1);
      else if (!cmd_hs && resp_take) outst_d = outst_q - OW'(1);
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_areset) begin
         state_q       <= S_IDLE;
         wptr_q        <= '0;
         base_q        <= '0;
         ring_q        <= '0;
         frame_addr_q  <= '0;
         frame_bytes_q <= '0;
         beats_rem_q   <= '0;
         burst_q       <= '0;
         cmd_q         <= '0;
         err_acc_q     <= 1'b0;
         outst_q       <= '0;
      end else begin
         state_q       <= state_d;
         wptr_q        <= wptr_d;
         base_q        <= base_d;
         ring_q        <= ring_d;
         frame_addr_q  <= frame_addr_d;
         frame_bytes_q <= frame_bytes_d;
         beats_rem_q   <= beats_rem_d;
         burst_q       <= burst_d;
         cmd_q         <= cmd_d;
         err_acc_q     <= err_acc_d;
         outst_q       <= outst_d;
      end
   end

   assign cmd_addr   = AXI_ADDR_WIDTH'(cmd_q.addr);
   assign cmd_len    = cmd_q.len;
   assign cmd_last   = cmd_q.last;
   assign done_addr  = frame_addr_q;
   assign done_bytes = frame_bytes_q;
   assign done_err   = err_acc_q;
   assign busy       = (state_q != S_IDLE) || (outst_q != '0);

endmodule

// File: tb/tb_axis_to_axi_wr_sched.sv
// Bench for the write-burst scheduler (32-bit data, 16-beat bursts, 4 outstanding).
module tb_axis_to_axi_wr_sched;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        axi_aclk = 1'b0;
   logic        axi_areset = 1'b1;
   logic        cfg_enable = 1'b0;
   logic [31:0] cfg_base_addr = '0;
   logic [31:0] cfg_ring_bytes = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [23:0] req_bytes = '0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        cmd_last;
   logic        bresp_valid = 1'b0;
   logic [1:0]  bresp = '0;
   logic        done_valid;
   logic [31:0] done_addr;
   logic [23:0] done_bytes;
   logic        done_err;
   logic        busy;

   axis_to_axi_wr_sched #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_MAX_BURST_LEN(16),
      .MAX_OUTSTANDING(4), .LEN_WIDTH(24)
   ) dut (
      .axi_aclk(axi_aclk), .axi_areset(axi_areset), .cfg_enable(cfg_enable),
      .cfg_base_addr(cfg_base_addr), .cfg_ring_bytes(cfg_ring_bytes),
      .req_valid(req_valid), .req_ready(req_ready), .req_bytes(req_bytes),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_last(cmd_last), .bresp_valid(bresp_valid),
      .bresp(bresp), .done_valid(done_valid), .done_addr(done_addr),
      .done_bytes(done_bytes), .done_err(done_err), .busy(busy)
   );

   always #5 axi_aclk = ~axi_aclk;

   int errors = 0;
   int checks = 0;
   logic [63:0] got_cmds[$];
   logic [63:0] got_done[$];
   logic [63:0] exp_cmds[$];
   logic [63:0] exp_done;
   int inflight = 0;
   int max_inflight = 0;
   longint unsigned mwptr = 0;

   // Writer-side monitor: records handshakes and completions, tracks bursts awaiting B.
   always @(negedge axi_aclk) begin
      if (axi_areset) begin
         inflight <= 0;
      end else begin
         if (cmd_valid && cmd_ready) got_cmds.push_back(64'({cmd_addr, cmd_len, cmd_last}));
         if (done_valid) got_done.push_back(64'({done_addr, done_bytes, done_err}));
         inflight <= inflight + int'(cmd_valid && cmd_ready) - int'(bresp_valid && inflight > 0);
         if (inflight + int'(cmd_valid && cmd_ready) > max_inflight)
            max_inflight <= inflight + int'(cmd_valid && cmd_ready);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the frame in bytes, cutting at 16 beats, 4 KB and ring end.
   task automatic model_frame(input int nbytes, input int err_idx);
      longint unsigned beats, w, a, n, lim, a0;
      beats = longint'((nbytes + 3) / 4);
      w  = mwptr;
      a0 = cfg_base_addr + mwptr;
      exp_cmds.delete();
      while (beats > 0) begin
         a = cfg_base_addr + w;
         n = beats;
         if (n > 16) n = 16;
         lim = (4096 - (a % 4096)) / 4;
         if (lim < n) n = lim;
         lim = (cfg_ring_bytes - w) / 4;
         if (lim < n) n = lim;
         exp_cmds.push_back(64'({32'(a), 8'(n - 1), (n == beats)}));
         w = w + n * 4;
         if (w == cfg_ring_bytes) w = 0;
         beats = beats - n;
      end
      exp_done = 64'({32'(a0), 24'(((nbytes + 3) / 4) * 4),
                      (err_idx >= 0 && err_idx < exp_cmds.size())});
      mwptr = w;
   endtask

   task automatic send_req(input int nbytes);
      int cnt;
      cnt = 0;
      @(posedge axi_aclk); #1;
      req_valid = 1'b1;
      req_bytes = 24'(nbytes);
      @(negedge axi_aclk);
      while (!req_ready && cnt < 100) begin
         cnt++;
         @(negedge axi_aclk);
      end
      chk("req_accept", 64'(req_ready), 64'd1);
      @(posedge axi_aclk); #1;
      req_valid = 1'b0;
      req_bytes = '0;
   endtask

   task automatic finish_frame(input int err_idx, input int rdy_pct, input int rsp_pct,
                               input bit zero_len, input string tag);
      int iters, given;
      bit seen;
      iters = 0; given = 0; seen = 0;
      while (!seen && iters < 3000) begin
         cmd_ready   = ($urandom_range(0, 99) < rdy_pct);
         bresp_valid = (inflight > 0) && ($urandom_range(0, 99) < rsp_pct);
         bresp       = (bresp_valid && given == err_idx) ? 2'b10 : 2'b00;
         if (bresp_valid) given++;
         @(posedge axi_aclk); #1;
         iters++;
         seen = (got_done.size() > 0);
      end
      cmd_ready = 1'b0; bresp_valid = 1'b0; bresp = '0;
      repeat (3) @(posedge axi_aclk);
      #1;
      chk({tag, "_done_pulses"}, 64'(got_done.size()), 64'd1);
      if (zero_len) chk({tag, "_zero_latency"}, 64'(iters), 64'd1);
      chk({tag, "_cmd_count"}, 64'(got_cmds.size()), 64'(exp_cmds.size()));
      for (int i = 0; i < exp_cmds.size() && i < got_cmds.size(); i++)
         chk($sformatf("%s_cmd%0d", tag, i), got_cmds[i], exp_cmds[i]);
      if (got_done.size() > 0) chk({tag, "_done"}, got_done[0], exp_done);
   endtask

   task automatic run_frame(input int nbytes, input int err_idx, input int rdy_pct,
                            input int rsp_pct, input string tag);
      logic [31:0] sv_base, sv_ring;
      sv_base = cfg_base_addr;
      sv_ring = cfg_ring_bytes;
      model_frame(nbytes, err_idx);
      got_cmds.delete();
      got_done.delete();
      send_req(nbytes);
      // Config moves mid-frame must not disturb the frame in progress.
      cfg_base_addr  = 32'h2000_0000;
      cfg_ring_bytes = 32'h0000_3000;
      cfg_enable     = 1'b0;
      finish_frame(err_idx, rdy_pct, rsp_pct, (nbytes == 0), tag);
      cfg_base_addr  = sv_base;
      cfg_ring_bytes = sv_ring;
      cfg_enable     = 1'b1;
   endtask

   initial begin
      int cnt, nb, e;

      repeat (3) @(posedge axi_aclk);
      #1;
      chk("reset_outputs", 64'({req_ready, cmd_valid, cmd_addr, cmd_len, cmd_last}), 64'd0);
      chk("reset_done", 64'({done_valid, done_addr, done_bytes, done_err, busy}), 64'd0);

      axi_areset     = 1'b0;
      cfg_base_addr  = BASE;
      cfg_ring_bytes = 32'h0001_0000;
      req_valid      = 1'b1;
      req_bytes      = 24'd64;
      repeat (5) @(posedge axi_aclk);
      #1;
      chk("disabled_req_ready", 64'(req_ready), 64'd0);
      chk("disabled_no_cmd", 64'(got_cmds.size()), 64'd0);
      chk("disabled_busy", 64'(busy), 64'd0);
      req_valid  = 1'b0;
      cfg_enable = 1'b1;

      run_frame(256, -1, 100, 100, "t1");
      for (int i = 0; i < 4 && i < got_cmds.size(); i++)
         chk($sformatf("t1_const%0d", i), got_cmds[i],
             64'({BASE + 32'(64 * i), 8'd15, (i == 3)}));
      if (got_done.size() > 0)
         chk("t1_done_const", got_done[0], 64'({BASE, 24'd256, 1'b0}));

      run_frame(256, 1, 70, 60, "t5_err");
      if (got_done.size() > 0) chk("t5_err_flag", 64'(got_done[0][0]), 64'd1);
      run_frame(5, -1, 100, 100, "t5_five");
      if (got_cmds.size() > 0) chk("t5_five_len", 64'(got_cmds[0][8:1]), 64'd1);
      if (got_done.size() > 0) chk("t5_five_bytes", 64'(got_done[0][24:1]), 64'd8);
      run_frame(0, -1, 100, 100, "t5_zero");
      if (got_done.size() > 0) chk("t5_zero_bytes", 64'(got_done[0][24:0]), 64'd0);

      run_frame(int'(64'h0FF0 - mwptr), -1, 100, 100, "t2_fill");
      run_frame(64, -1, 100, 100, "t2");
      if (got_cmds.size() == 2) begin
         chk("t2_split_a", got_cmds[0], 64'({32'h1000_0FF0, 8'd3, 1'b0}));
         chk("t2_split_b", got_cmds[1], 64'({32'h1000_1000, 8'd11, 1'b1}));
      end

      cfg_ring_bytes = 32'h0000_2000;
      run_frame(int'(64'h1FE0 - mwptr), -1, 100, 100, "t3_fill");
      run_frame(64, -1, 100, 100, "t3");
      if (got_cmds.size() == 2) begin
         chk("t3_wrap_a", got_cmds[0], 64'({32'h1000_1FE0, 8'd7, 1'b0}));
         chk("t3_wrap_b", got_cmds[1], 64'({32'h1000_0000, 8'd7, 1'b1}));
      end
      run_frame(4, -1, 100, 100, "t3_next");
      if (got_done.size() > 0) chk("t3_next_addr", 64'(got_done[0][56:25]), 64'h1000_0020);

      for (int k = 0; k < 24; k++) begin
         nb = int'($urandom_range(0, 700));
         e  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
         run_frame(nb, e, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                   $sformatf("rnd%0d", k));
      end

      // Outstanding cap with responses held off.
      model_frame(512, -1);
      got_cmds.delete();
      got_done.delete();
      send_req(512);
      cmd_ready = 1'b1;
      repeat (12) @(posedge axi_aclk);
      #1;
      chk("t4_cap_cmds", 64'(got_cmds.size()), 64'd4);
      chk("t4_cap_valid", 64'(cmd_valid), 64'd0);
      chk("t4_cap_inflight", 64'(inflight), 64'd4);
      bresp_valid = 1'b1;
      @(posedge axi_aclk); #1;
      bresp_valid = 1'b0;
      repeat (10) @(posedge axi_aclk);
      #1;
      chk("t4_one_resp_cmds", 64'(got_cmds.size()), 64'd5);
      chk("t4_one_resp_valid", 64'(cmd_valid), 64'd0);
      // Second response cycle coincides with the 6th handshake.
      bresp_valid = 1'b1;
      repeat (2) @(posedge axi_aclk);
      #1;
      bresp_valid = 1'b0;
      repeat (10) @(posedge axi_aclk);
      #1;
      chk("t4_simul_cmds", 64'(got_cmds.size()), 64'd7);
      chk("t4_simul_valid", 64'(cmd_valid), 64'd0);
      finish_frame(-1, 100, 100, 1'b0, "t4");

      // Reset in the middle of a frame.
      got_cmds.delete();
      got_done.delete();
      send_req(256);
      cmd_ready = 1'b1;
      cnt = 0;
      while (got_cmds.size() < 3 && cnt < 50) begin
         @(posedge axi_aclk); #1;
         cnt++;
      end
      cmd_ready = 1'b0;
      chk("t6_pre_cmds", 64'(got_cmds.size()), 64'd3);
      repeat (2) @(posedge axi_aclk);
      #1;
      chk("t6_pre_valid", 64'(cmd_valid), 64'd1);
      axi_areset = 1'b1;
      @(posedge axi_aclk); #1;
      chk("t6_rst_valid", 64'(cmd_valid), 64'd0);
      chk("t6_rst_busy", 64'(busy), 64'd0);
      chk("t6_rst_out", 64'({cmd_addr, done_valid}), 64'd0);
      axi_areset = 1'b0;
      mwptr = 0;
      bresp_valid = 1'b1;
      repeat (2) @(posedge axi_aclk);
      #1;
      bresp_valid = 1'b0;
      @(posedge axi_aclk); #1;
      chk("t6_stale_resp_busy", 64'(busy), 64'd0);
      run_frame(16, -1, 100, 100, "t6_after");
      if (got_cmds.size() > 0) chk("t6_after_const", got_cmds[0], 64'({BASE, 8'd3, 1'b1}));

      chk("max_inflight", 64'(max_inflight <= 4), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
